stc_frame_sync: RTL and testbench

- Bit-serial frame synchronizer directly downstream of the STC derandomizer.
- Consumes the derandomized bit stream and its bit enable, and correlates a 32-bit window against a programmable sync pattern, in both true and inverted polarity.
- Runs a search/verify/lock/flywheel state machine.
- Outputs a polarity-corrected bit stream, a frame-start strobe and lock status to the downstream frame buffer/deframer.

---
 rtl/stc_frame_sync_if.sv | 22 ++
 rtl/stc_frame_sync.sv | 165 ++++++++++++++++
 tb/tb_stc_frame_sync.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/stc_frame_sync_if.sv
// Bit-stream bus between the STC derandomizer, the frame synchronizer and the downstream deframer.
// The master drives the input stream and the slave (the synchronizer) returns the corrected stream and status.
interface stc_frame_sync_if;
  logic       bitInputEn;
  logic       bitInput;
  logic       bitOutputEn;
  logic       bitOutput;
  logic       frameStart;
  logic       locked;
  logic [1:0] syncState;
  logic       inverted;

  modport master (
    output bitInputEn, bitInput,
    input  bitOutputEn, bitOutput, frameStart, locked, syncState, inverted
  );

  modport slave (
    input  bitInputEn, bitInput,
    output bitOutputEn, bitOutput, frameStart, locked, syncState, inverted
  );
endinterface

// File: rtl/stc_frame_sync.sv
// Bit-serial STC frame synchronizer: correlates a sliding window against the sync word in both
// polarities and runs a search/verify/lock/flywheel tracker over the frame period.
module stc_frame_sync #(
  parameter int SYNC_W  = 32,
  parameter int FRAME_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SYNC_W-1:0]  syncPattern,
  input  logic [SYNC_W-1:0]  syncMask,
  input  logic [FRAME_W-1:0] frameLength,
  input  logic [3:0]         searchTol,
  input  logic [3:0]         lockTol,
  input  logic [2:0]         verifyCount,
  input  logic [2:0]         flywheelCount,
  stc_frame_sync_if.slave    bus
);

  localparam int CNT_W = $clog2(SYNC_W + 1);

  typedef enum logic [1:0] {
    SEARCH   = 2'd0,
    VERIFY   = 2'd1,
    LOCK     = 2'd2,
    FLYWHEEL = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [SYNC_W-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < SYNC_W; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

  state_t             state, state_nxt;
  logic [SYNC_W-1:0]  window, win_nxt;
  logic [FRAME_W-1:0] bit_count, count_nxt;
  logic [2:0]         hits, hits_nxt;
  logic [3:0]         misses, misses_nxt;
  logic               invert, invert_nxt;
  logic               frame_start_nxt;

  logic [CNT_W-1:0]   d_true, d_inv;
  logic               lock_hit, at_check, short_frame, sync_evt;

  logic               vld_p1;
  logic               bit_out_p1;
  logic               frame_start_p1;

  // Stage 0: window update, distance measurement and tracker next-state
  always_comb begin
    state_nxt   = state;
    count_nxt   = bit_count;
    hits_nxt    = hits;
    misses_nxt  = misses;
    invert_nxt  = invert;
    sync_evt    = 1'b0;

    win_nxt     = {window[SYNC_W-2:0], bus.bitInput};
    d_true      = popcount((win_nxt ^ syncPattern) & syncMask);
    d_inv       = popcount((win_nxt ^ ~syncPattern) & syncMask);
    lock_hit    = (invert ? d_inv : d_true) <= CNT_W'(lockTol);
    at_check    = (bit_count == frameLength - FRAME_W'(1));
    short_frame = (frameLength < FRAME_W'(SYNC_W + 1));

    if (short_frame) begin
      // A frame shorter than the sync word cannot be tracked; keep hunting.
      state_nxt  = SEARCH;
      count_nxt  = '0;
      hits_nxt   = '0;
      misses_nxt = '0;
    end else begin
      unique case (state)
        SEARCH: begin
          count_nxt = '0;
          if (d_true <= CNT_W'(searchTol) || d_inv <= CNT_W'(searchTol)) begin
            // True polarity takes priority when both correlate.
            invert_nxt = !(d_true <= CNT_W'(searchTol));
            hits_nxt   = 3'd1;
            misses_nxt = '0;
            sync_evt   = 1'b1;
            state_nxt  = (verifyCount <= 3'd1) ? LOCK : VERIFY;
          end
        end
        default: begin
          if (at_check) begin
            count_nxt = '0;
            sync_evt  = 1'b1;
            unique case (state)
              VERIFY: begin
                if (lock_hit) begin
                  hits_nxt = hits + 3'd1;
                  if ({1'b0, hits} + 4'd1 >= {1'b0, verifyCount}) state_nxt = LOCK;
                end else begin
                  state_nxt = SEARCH;
                  hits_nxt  = '0;
                end
              end
              LOCK: begin
                if (!lock_hit) begin
                  state_nxt  = FLYWHEEL;
                  misses_nxt = 4'd1;
                end
              end
              default: begin
                if (lock_hit) begin
                  state_nxt  = LOCK;
                  misses_nxt = '0;
                end else if (misses + 4'd1 > {1'b0, flywheelCount}) begin
                  state_nxt  = SEARCH;
                  misses_nxt = '0;
                  hits_nxt   = '0;
                end else begin
                  misses_nxt = misses + 4'd1;
                end
              end
            endcase
          end else begin
            count_nxt = bit_count + FRAME_W'(1);
          end
        end
      endcase
    end

    frame_start_nxt = sync_evt && (state_nxt == LOCK || state_nxt == FLYWHEEL);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= SEARCH;
      window         <= '0;
      bit_count      <= '0;
      hits           <= '0;
      misses         <= '0;
      invert         <= 1'b0;
      vld_p1         <= 1'b0;
      bit_out_p1     <= 1'b0;
      frame_start_p1 <= 1'b0;
    end else if (bus.bitInputEn) begin
      state          <= state_nxt;
      window         <= win_nxt;
      bit_count      <= count_nxt;
      hits           <= hits_nxt;
      misses         <= misses_nxt;
      invert         <= invert_nxt;
      vld_p1         <= 1'b1;
      bit_out_p1     <= bus.bitInput ^ invert_nxt;
      frame_start_p1 <= frame_start_nxt;
    end else begin
      vld_p1         <= 1'b0;
      frame_start_p1 <= 1'b0;
    end
  end

  // Stage 1: registered outputs
  assign bus.bitOutputEn = vld_p1;
  assign bus.bitOutput   = bit_out_p1;
  assign bus.frameStart  = frame_start_p1;
  assign bus.locked      = (state == LOCK) || (state == FLYWHEEL);
  assign bus.syncState   = state;
  assign bus.inverted    = invert;

endmodule

// File: tb/tb_stc_frame_sync.sv
// Scoreboard bench for stc_frame_sync: a reference model predicts every output bit from the sync rules,
// and a monitor compares the DUT output stream against the queued predictions.
`timescale 1ns/1ps
module tb_stc_frame_sync;

  typedef struct packed {
    logic       bo;
    logic       fs;
    logic [1:0] st;
    logic       lk;
    logic       inv;
  } exp_t;

  localparam int M_SEARCH = 0, M_VERIFY = 1, M_LOCK = 2, M_FLY = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pat, mask;
  logic [15:0] flen;
  logic [3:0]  stol, ltol;
  logic [2:0]  vcnt, fcnt;

  stc_frame_sync_if bus();

  stc_frame_sync #(.SYNC_W(32), .FRAME_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .syncPattern  (pat),
    .syncMask     (mask),
    .frameLength  (flen),
    .searchTol    (stol),
    .lockTol      (ltol),
    .verifyCount  (vcnt),
    .flywheelCount(fcnt),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   fs_count = 0;
  bit   mon_en = 1'b0;
  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model: tracks absolute bit index and the index at which the next sync must end.
  logic [31:0] m_win;
  int          m_state, m_hits, m_miss;
  bit          m_inv;
  longint      bit_idx, next_sync;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_win = '0; m_state = M_SEARCH; m_hits = 0; m_miss = 0; m_inv = 1'b0;
    bit_idx = 0; next_sync = 0;
  endtask

  task automatic model_step(input logic b, output exp_t e);
    int dt, di, v;
    bit found, hit;
    m_win = {m_win[30:0], b};
    bit_idx++;
    dt = $countones((m_win ^ pat) & mask);
    di = $countones((m_win ^ ~pat) & mask);
    v  = (vcnt == 0) ? 1 : int'(vcnt);
    e.fs = 1'b0;
    if (flen < 33) begin
      m_state = M_SEARCH; m_hits = 0; m_miss = 0;
    end else if (m_state == M_SEARCH) begin
      found = 1'b1;
      if (dt <= int'(stol)) m_inv = 1'b0;
      else if (di <= int'(stol)) m_inv = 1'b1;
      else found = 1'b0;
      if (found) begin
        m_hits = 1; m_miss = 0;
        next_sync = bit_idx + longint'(flen);
        m_state = (v <= 1) ? M_LOCK : M_VERIFY;
        e.fs = (m_state == M_LOCK);
      end
    end else if (bit_idx == next_sync) begin
      next_sync = bit_idx + longint'(flen);
      hit = ((m_inv ? di : dt) <= int'(ltol));
      if (m_state == M_VERIFY) begin
        if (hit) begin
          m_hits++;
          if (m_hits >= v) m_state = M_LOCK;
        end else m_state = M_SEARCH;
      end else if (m_state == M_LOCK) begin
        if (!hit) begin m_state = M_FLY; m_miss = 1; end
      end else begin
        if (hit) begin m_state = M_LOCK; m_miss = 0; end
        else begin
          m_miss++;
          if (m_miss > int'(fcnt)) m_state = M_SEARCH;
        end
      end
      e.fs = (m_state == M_LOCK || m_state == M_FLY);
    end
    e.bo  = b ^ m_inv;
    e.st  = 2'(m_state);
    e.lk  = (m_state >= M_LOCK);
    e.inv = m_inv;
  endtask

  task automatic send_bit(input logic b, input int gap);
    exp_t e;
    @(posedge clk); #1;
    bus.bitInputEn = 1'b1;
    bus.bitInput   = b;
    model_step(b, e);
    exp_q.push_back(e);
    repeat (gap) begin
      @(posedge clk); #1;
      bus.bitInputEn = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.bitInputEn = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [31:0] sw, input logic [31:0] corr, input bit inv_all, input int gap);
    logic [31:0] w;
    w = sw ^ corr;
    for (int i = 0; i < 32; i++) send_bit(w[31-i] ^ inv_all, gap);
    for (int i = 32; i < int'(flen); i++) send_bit(1'($urandom_range(0, 1)), gap);
  endtask

  function automatic logic [31:0] rand_errs(input int k);
    logic [31:0] m;
    int p;
    m = '0;
    while ($countones(m) < k) begin
      p = $urandom_range(0, 31);
      m[p] = 1'b1;
    end
    return m;
  endfunction

  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    bus.bitInputEn = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk({tag, "_rst_outs"}, {26'd0, bus.bitOutputEn, bus.bitOutput, bus.frameStart,
        bus.locked, bus.syncState}, 32'd0);
    chk({tag, "_rst_inv"}, {31'd0, bus.inverted}, 32'd0);
    model_reset();
    exp_q.delete();
    mon_en = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.bitOutputEn === 1'b1) begin
        if (exp_q.size() == 0) chk("unexpected_output", 32'd1, 32'd0);
        else begin
          mon_e = exp_q.pop_front();
          chk("stream_out", {26'd0, bus.bitOutput, bus.frameStart, bus.syncState, bus.locked, bus.inverted},
              {26'd0, mon_e});
          if (bus.frameStart === 1'b1) fs_count++;
        end
      end else begin
        chk("fs_when_idle", {31'd0, bus.frameStart}, 32'd0);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sw;
    bus.bitInputEn = 1'b0;
    bus.bitInput   = 1'b0;
    pat = 32'hFE6B2840; mask = 32'hFFFFFFFF; flen = 16'd256;
    stol = 4'd0; ltol = 4'd2; vcnt = 3'd3; fcnt = 3'd2;
    model_reset();
    repeat (3) @(posedge clk);

    // Clean frames: VERIFY, VERIFY, LOCK, then steady lock
    do_reset("t1");
    fs_count = 0;
    send_frame(pat, 0, 1'b0, 0); idle(1);
    chk("t1_verify_after_1st", {30'd0, bus.syncState}, 32'd1);
    send_frame(pat, 0, 1'b0, 0); idle(1);
    chk("t1_verify_after_2nd", {30'd0, bus.syncState}, 32'd1);
    send_frame(pat, 0, 1'b0, 0); idle(1);
    chk("t1_lock_after_3rd", {30'd0, bus.syncState}, 32'd2);
    send_frame(pat, 0, 1'b0, 0);
    send_frame(pat, 0, 1'b0, 0); idle(2);
    chk("t1_fs_pulses", fs_count, 32'd3);

    // Flywheel behaviour with flywheelCount=2
    send_frame(pat, rand_errs(3), 1'b0, 0); idle(1);
    chk("t3_flywheel", {30'd0, bus.syncState}, 32'd3);
    send_frame(pat, 0, 1'b0, 0); idle(1);
    chk("t3_relock", {30'd0, bus.syncState}, 32'd2);
    for (int k = 0; k < 3; k++) send_frame(pat, rand_errs(3), 1'b0, 0);
    idle(1);
    chk("t3_search_after_3_miss", {30'd0, bus.syncState}, 32'd0);

    // Two-error sync tolerated while locked, rejected in SEARCH with searchTol=1
    do_reset("t4");
    for (int k = 0; k < 3; k++) send_frame(pat, 0, 1'b0, 0);
    send_frame(pat, rand_errs(2), 1'b0, 0); idle(1);
    chk("t4_lock_2err", {30'd0, bus.syncState}, 32'd2);
    do_reset("t4b");
    stol = 4'd1;
    for (int k = 0; k < 4; k++) send_frame(pat, rand_errs(2), 1'b0, 0);
    idle(1);
    chk("t4_no_acquire", {30'd0, bus.syncState}, 32'd0);
    stol = 4'd0;

    // Inverted stream
    do_reset("t2");
    for (int k = 0; k < 4; k++) send_frame(pat, 0, 1'b1, 0);
    idle(1);
    chk("t2_inverted", {31'd0, bus.inverted}, 32'd1);
    chk("t2_locked", {31'd0, bus.locked}, 32'd1);
    send_bit(1'b0, 0); idle(1);
    chk("t2_bit_corrected", {31'd0, bus.bitOutput}, 32'd1);

    // Sparse enables with a reset mid-frame while locked
    do_reset("t5");
    vcnt = 3'($urandom_range(2, 3));
    for (int k = 0; k < 3; k++) send_frame(pat, 0, 1'b0, 3);
    for (int k = 0; k < 100; k++) send_bit(1'($urandom_range(0, 1)), 3);
    chk("t5_locked_before_rst", {31'd0, bus.locked}, 32'd1);
    do_reset("t5mid");
    vcnt = 3'd3;
    send_frame(pat, 0, 1'b0, 3); idle(1);
    chk("t5_reverify", {30'd0, bus.syncState}, 32'd1);
    send_frame(pat, 0, 1'b0, 3);
    send_frame(pat, 0, 1'b0, 3); idle(1);
    chk("t5_relock", {30'd0, bus.syncState}, 32'd2);

    // Partial mask with random unmasked bits; then an illegal short frame length
    do_reset("t6");
    mask = 32'hFFFF0000;
    for (int k = 0; k < 4; k++) begin
      sw = {pat[31:16], 16'($urandom)};
      send_frame(sw, 0, 1'b0, 0);
    end
    idle(1);
    chk("t6_mask_lock", {31'd0, bus.locked}, 32'd1);
    flen = 16'd20;
    for (int k = 0; k < 10; k++) send_frame(pat, 0, 1'b0, 0);
    idle(1);
    chk("t6_short_search", {30'd0, bus.syncState}, 32'd0);

    idle(3);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
